// File: rtl/slim_anim_ctrl.sv
// Slim enemy sprite sequencer: tick divider, walk/frozen/thaw FSM, 16-step frame schedule
// and a mirrored sprite-ROM address path.
module slim_anim_ctrl #(
  parameter int unsigned SPR_W        = 34,
  parameter int unsigned SPR_H        = 33,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned TICK_DIV     = 6000000,
  parameter int unsigned FROZEN_TICKS = 48,
  parameter int unsigned THAW_TICKS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              dir_in,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        frame_sel,
  output logic              frozen,
  output logic              mirror,
  output logic              thawing,
  output logic [3:0]        anim_step
);

  localparam int unsigned TMax = (FROZEN_TICKS > THAW_TICKS) ? FROZEN_TICKS : THAW_TICKS;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [31:0]       DivMax   = 32'(TICK_DIV - 1);
  localparam logic [TW-1:0]     FrzLoad  = TW'(FROZEN_TICKS - 1);
  localparam logic [TW-1:0]     ThawLoad = TW'(THAW_TICKS - 1);
  localparam logic [TW-1:0]     TimerOne = TW'(1);
  localparam logic [ADDR_W-1:0] SprW     = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] SprWm1   = ADDR_W'(SPR_W - 1);
  localparam logic [ADDR_W-1:0] NumPix   = ADDR_W'(SPR_W * SPR_H);

  typedef enum logic [1:0] {StWalk, StFrozen, StThaw} state_e;

  state_e            state_q, state_d;
  logic [31:0]       div_q, div_d;
  logic [3:0]        step_q, step_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              frozen_q, frozen_d;
  logic              mirror_q, mirror_d;
  logic [1:0]        frame_q, frame_d;
  logic [ADDR_W-1:0] rom_q, rom_d;
  logic [ADDR_W-1:0] col;
  logic              tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StWalk;
      div_q    <= '0;
      step_q   <= '0;
      timer_q  <= '0;
      frozen_q <= 1'b0;
      mirror_q <= 1'b0;
      frame_q  <= '0;
      rom_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      step_q   <= step_d;
      timer_q  <= timer_d;
      frozen_q <= frozen_d;
      mirror_q <= mirror_d;
      frame_q  <= frame_d;
      rom_q    <= rom_d;
    end
  end

  // Divider free-runs; only reset clears it.
  always_comb begin
    tick  = (div_q == DivMax);
    div_d = tick ? '0 : div_q + 32'd1;
  end

  // A hit always overrides a coincident tick, so it is tested before tick in every state.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    timer_d  = timer_q;
    frozen_d = frozen_q;
    mirror_d = mirror_q;
    if (tick) begin
      step_d = step_q + 4'd1;
    end
    case (state_q)
      StWalk: begin
        frozen_d = 1'b0;
        if (hit) begin
          state_d  = StFrozen;
          timer_d  = FrzLoad;
          step_d   = '0;
          frozen_d = 1'b1;
        end else if (tick) begin
          mirror_d = dir_in;
        end
      end
      StFrozen: begin
        frozen_d = 1'b1;
        if (hit) begin
          timer_d = FrzLoad;
          step_d  = '0;
        end else if (tick) begin
          if (timer_q == '0) begin
            state_d = StThaw;
            timer_d = ThawLoad;
            step_d  = '0;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
      end
      StThaw: begin
        if (hit) begin
          state_d  = StFrozen;
          timer_d  = FrzLoad;
          step_d   = '0;
          frozen_d = 1'b1;
        end else if (tick) begin
          if (timer_q == '0) begin
            state_d  = StWalk;
            step_d   = '0;
            frozen_d = 1'b0;
          end else begin
            timer_d  = timer_q - TimerOne;
            frozen_d = ~frozen_q;
          end
        end
      end
      default: begin
        state_d  = StWalk;
        step_d   = '0;
        frozen_d = 1'b0;
      end
    endcase
  end

  // Frozen frames linger longer on the middle pose.
  always_comb begin
    if (step_q < 4'd2) begin
      frame_d = 2'd0;
    end else if (state_q == StFrozen) begin
      frame_d = (step_q < 4'd8) ? 2'd1 : 2'd2;
    end else begin
      frame_d = (step_q < 4'd6) ? 2'd1 : 2'd2;
    end
  end

  // Mirrored index row*W + (W-1-col) simplifies to pix + (W-1) - 2*col.
  always_comb begin
    col = pix_addr % SprW;
    if (pix_addr >= NumPix) begin
      rom_d = '0;
    end else if (mirror_q) begin
      rom_d = pix_addr + SprWm1 - {col[ADDR_W-2:0], 1'b0};
    end else begin
      rom_d = pix_addr;
    end
  end

  assign rom_addr  = rom_q;
  assign frame_sel = frame_q;
  assign frozen    = frozen_q;
  assign mirror    = mirror_q;
  assign thawing   = (state_q == StThaw);
  assign anim_step = step_q;

endmodule

// File: doc/slim_anim_ctrl.md
Name: slim_anim_ctrl

Overview:
- Sequencer for the slim enemy sprite. It owns the animation tick divider, the walk/frozen/thaw state machine, the 16-step frame schedule and the facing direction.
- It emits the frame select, the frozen flag and a mirrored sprite-ROM address.
- It sits between game logic (direction, freeze hits) and the slim sprite ROM bank/mux that feeds the VGA pixel path.

Parameters:
- SPR_W, 34, sprite width in pixels.
- SPR_H, 33, sprite height in pixels.
- ADDR_W, 14, sprite ROM address width.
- TICK_DIV, 6000000, clk cycles per animation tick.
- FROZEN_TICKS, 48, ticks spent fully frozen.
- THAW_TICKS, 8, ticks spent blinking before walking resumes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- hit  in  1  one-cycle freeze pulse from snowball collision
- dir_in  in  1  requested facing: 0 = left, 1 = right
- pix_addr  in  ADDR_W  raw row-major sprite pixel index, row*SPR_W + col
- rom_addr  out  ADDR_W  address to sprite ROMs, mirrored when facing right
- frame_sel  out  2  0/1/2 = first/second/third animation frame
- frozen  out  1  1 = select frozen ROM set
- mirror  out  1  current facing, 1 = right
- thawing  out  1  high during THAW
- anim_step  out  4  current schedule step 0..15

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces the following, regardless of state:
  - state = WALK; divider = 0; step = 0; timer = 0.
  - All outputs 0.
- Divider:
  - 32-bit counter runs 0..TICK_DIV-1, then wraps to 0.
  - tick is asserted for one cycle when the count equals TICK_DIV-1.
  - The divider is never cleared except by reset.
- Step counter:
  - Advances by 1 on each tick and wraps 15 -> 0.
  - Forced to 0 on any state entry.
- frame_sel is a registered function of step and state:
  - WALK/THAW: steps 0-1 -> 0; steps 2-5 -> 1; steps 6-15 -> 2.
  - FROZEN: steps 0-1 -> 0; steps 2-7 -> 1; steps 8-15 -> 2.
  - Outputs update the cycle after step changes.
- States:
  - WALK:
    - frozen = 0, thawing = 0.
    - On tick, mirror <= dir_in. Direction is sampled only on ticks, so there is no mid-frame flip.
    - hit -> FROZEN, with timer = FROZEN_TICKS-1.
  - FROZEN:
    - frozen = 1; mirror is held.
    - On tick: if timer == 0 -> THAW with timer = THAW_TICKS-1; otherwise timer decrements.
    - hit -> reloads timer = FROZEN_TICKS-1 and sets step = 0 (refreeze). The state is unchanged.
  - THAW:
    - thawing = 1; mirror is held.
    - frozen starts at 1 on entry and toggles on every tick (blink).
    - On tick with timer == 0 -> WALK, with frozen = 0 and step = 0; otherwise timer decrements.
    - hit -> FROZEN, with timer = FROZEN_TICKS-1 and frozen = 1.
- Simultaneous events:
  - hit and tick in the same cycle: hit wins. The tick's step advance and timer decrement are discarded.
  - hit during reset is ignored.
- Address path:
  - 1-cycle registered latency.
  - col = pix_addr mod SPR_W; row = pix_addr div SPR_W.
  - mirror = 1: rom_addr = row*SPR_W + (SPR_W-1-col). mirror = 0: rom_addr = pix_addr.
  - The mirror value used is the one registered in the same cycle pix_addr is sampled.
  - pix_addr >= SPR_W*SPR_H: rom_addr = 0.
  - Arithmetic is carried at ADDR_W bits with no overflow, since SPR_W*SPR_H < 2^ADDR_W.
- Widths: timer is wide enough for max(FROZEN_TICKS, THAW_TICKS)-1, i.e. 6 bits at defaults.

Test Plan:
- Setup for all scenarios: TICK_DIV = 4, FROZEN_TICKS = 3, THAW_TICKS = 2.
- Walk schedule: no hit, dir_in = 0; run 17 ticks -> frame_sel sequence is 0,0,1,1,1,1,2×10, then wraps to 0; frozen = 0; mirror = 0.
- Mirror address: dir_in = 1, wait one tick, then drive pix_addr = 0, 33, 34, 1121, 1122 -> one cycle later rom_addr = 33, 0, 67, 1088, 0.
- Freeze/thaw timing:
  - Pulse hit -> next cycle frozen = 1, step = 0.
  - After 3 ticks -> thawing = 1, frozen = 1.
  - Next tick -> frozen = 0.
  - Next tick -> WALK: frozen = 0, thawing = 0, step = 0.
  - FROZEN frame_sel follows the 0,0,1×6,2×8 schedule.
- Refreeze and collisions:
  - hit on the same cycle as tick while in FROZEN with timer = 0 -> stays FROZEN, timer = 2, step = 0.
  - hit during THAW -> FROZEN.
  - dir_in toggled while frozen -> mirror unchanged until WALK resumes and a tick occurs.
- Reset mid-operation: assert rst_n = 0 for 1 cycle while in THAW -> next cycle all outputs 0, state WALK, divider restarts with the first tick 4 cycles after release.
